// File: rtl/ddr2_v10_1_sequencer_avl_master_if.sv
// Request/response channel and Avalon-MM bus between the calibration core,
// the sequencer Avalon master and the rw_mgr slave.
interface ddr2_v10_1_sequencer_avl_master_if #(
   parameter int AVL_DATA_WIDTH    = 32,
   parameter int AVL_ADDRESS_WIDTH = 16
);
   logic                         req_valid;
   logic                         req_ready;
   logic [1:0]                   req_op;
   logic [AVL_ADDRESS_WIDTH-1:0] req_address;
   logic [AVL_DATA_WIDTH-1:0]    req_wdata;
   logic [AVL_DATA_WIDTH-1:0]    req_mask;

   logic [AVL_ADDRESS_WIDTH-1:0] avl_address;
   logic                         avl_write;
   logic [AVL_DATA_WIDTH-1:0]    avl_writedata;
   logic                         avl_read;
   logic [AVL_DATA_WIDTH-1:0]    avl_readdata;
   logic                         avl_waitrequest;

   logic                         rsp_valid;
   logic [AVL_DATA_WIDTH-1:0]    rsp_rdata;
   logic                         rsp_timeout;
   logic                         rsp_match;

   modport master (
      input  req_valid, req_op, req_address, req_wdata, req_mask,
      output req_ready,
      output avl_address, avl_write, avl_writedata, avl_read,
      input  avl_readdata, avl_waitrequest,
      output rsp_valid, rsp_rdata, rsp_timeout, rsp_match
   );

   modport slave (
      output req_valid, req_op, req_address, req_wdata, req_mask,
      input  req_ready,
      input  avl_address, avl_write, avl_writedata, avl_read,
      output avl_readdata, avl_waitrequest,
      input  rsp_valid, rsp_rdata, rsp_timeout, rsp_match
   );
endinterface

// File: rtl/ddr2_v10_1_sequencer_avl_master.sv
// Avalon-MM master issuing single-word WRITE/READ/POLL transfers to the rw_mgr
// slave, with a mandatory idle cycle between transfers and a stall timeout.
module ddr2_v10_1_sequencer_avl_master #(
   parameter int AVL_DATA_WIDTH    = 32,
   parameter int AVL_ADDRESS_WIDTH = 16,
   parameter int TIMEOUT_CYCLES    = 4096,
   parameter int POLL_LIMIT        = 256
) (
   input logic avl_clk,
   input logic avl_reset,
   ddr2_v10_1_sequencer_avl_master_if.master bus
);

   //  state    | meaning
   //  S_IDLE   | ready for a request, strobes low
   //  S_ACCESS | strobe asserted, waiting for waitrequest low or timeout
   //  S_GAP    | one idle bus cycle, POLL compare / re-issue decision
   //  S_RESP   | rsp_valid pulse
   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_GAP, S_RESP} state_t;

   localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam int POLL_W = $clog2(POLL_LIMIT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_LIMIT - 1);

   state_t                       state_q;
   logic                         is_write_q, is_poll_q;
   logic [AVL_ADDRESS_WIDTH-1:0] addr_q;
   logic [AVL_DATA_WIDTH-1:0]    wdata_q, mask_q, rdata_q;
   logic                         read_q, write_q;
   logic [WAIT_W-1:0]            wait_cnt_q;
   logic [POLL_W-1:0]            poll_cnt_q;
   logic                         rsp_valid_q, rsp_timeout_q, rsp_match_q;
   logic [AVL_DATA_WIDTH-1:0]    rsp_rdata_q;
   logic                         poll_hit;

   assign poll_hit = (((rdata_q ^ wdata_q) & mask_q) == '0);

   always_ff @(posedge avl_clk or posedge avl_reset) begin
      if (avl_reset) begin
         state_q       <= S_IDLE;
         is_write_q    <= 1'b0;
         is_poll_q     <= 1'b0;
         addr_q        <= '0;
         wdata_q       <= '0;
         mask_q        <= '0;
         rdata_q       <= '0;
         read_q        <= 1'b0;
         write_q       <= 1'b0;
         wait_cnt_q    <= '0;
         poll_cnt_q    <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_timeout_q <= 1'b0;
         rsp_match_q   <= 1'b0;
         rsp_rdata_q   <= '0;
      end else begin
         rsp_valid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (bus.req_valid) begin
                  is_write_q <= (bus.req_op == 2'b00);
                  is_poll_q  <= (bus.req_op == 2'b10);
                  addr_q     <= bus.req_address;
                  wdata_q    <= bus.req_wdata;
                  mask_q     <= bus.req_mask;
                  rdata_q    <= '0;
                  wait_cnt_q <= '0;
                  poll_cnt_q <= '0;
                  write_q    <= (bus.req_op == 2'b00);
                  read_q     <= (bus.req_op != 2'b00);
                  state_q    <= S_ACCESS;
               end
            end
            S_ACCESS: begin
               if (!bus.avl_waitrequest) begin
                  if (read_q) rdata_q <= bus.avl_readdata;
                  read_q  <= 1'b0;
                  write_q <= 1'b0;
                  state_q <= S_GAP;
               end else begin
                  wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
                  // Last permitted stall cycle: abort straight to RESP, no GAP.
                  if (wait_cnt_q == WAIT_LAST) begin
                     read_q        <= 1'b0;
                     write_q       <= 1'b0;
                     rsp_valid_q   <= 1'b1;
                     rsp_timeout_q <= 1'b1;
                     rsp_match_q   <= 1'b0;
                     rsp_rdata_q   <= rdata_q;
                     state_q       <= S_RESP;
                  end
               end
            end
            S_GAP: begin
               if (is_poll_q && !poll_hit && (poll_cnt_q != POLL_LAST)) begin
                  poll_cnt_q <= poll_cnt_q + POLL_W'(1);
                  wait_cnt_q <= '0;
                  read_q     <= 1'b1;
                  state_q    <= S_ACCESS;
               end else begin
                  rsp_valid_q   <= 1'b1;
                  rsp_timeout_q <= 1'b0;
                  rsp_match_q   <= is_poll_q && poll_hit;
                  rsp_rdata_q   <= is_write_q ? '0 : rdata_q;
                  state_q       <= S_RESP;
               end
            end
            S_RESP:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.req_ready     = (state_q == S_IDLE);
   assign bus.avl_address   = addr_q;
   assign bus.avl_writedata = wdata_q;
   assign bus.avl_write     = write_q;
   assign bus.avl_read      = read_q;
   assign bus.rsp_valid     = rsp_valid_q;
   assign bus.rsp_rdata     = rsp_rdata_q;
   assign bus.rsp_timeout   = rsp_timeout_q;
   assign bus.rsp_match     = rsp_match_q;

endmodule

// File: tb/tb_ddr2_v10_1_sequencer_avl_master.sv
// Directed bench for the sequencer Avalon master: vector table of requests with
// a behavioural rw_mgr slave, plus reset-during-access sequence.
module tb_ddr2_v10_1_sequencer_avl_master;

   localparam int DW = 32;
   localparam int AW = 16;

   logic avl_clk   = 1'b0;
   logic avl_reset = 1'b1;
   int   errors    = 0;
   int   checks    = 0;

   always #5 avl_clk = ~avl_clk;

   ddr2_v10_1_sequencer_avl_master_if #(.AVL_DATA_WIDTH(DW), .AVL_ADDRESS_WIDTH(AW)) bus ();

   ddr2_v10_1_sequencer_avl_master #(
      .AVL_DATA_WIDTH(DW), .AVL_ADDRESS_WIDTH(AW),
      .TIMEOUT_CYCLES(8), .POLL_LIMIT(4)
   ) dut (
      .avl_clk   (avl_clk),
      .avl_reset (avl_reset),
      .bus       (bus.master)
   );

   typedef struct {
      logic [1:0]        op;
      logic [AW-1:0]     addr;
      logic [DW-1:0]     wdata;
      logic [DW-1:0]     mask;
      int                waits;     // stall cycles per beat (255 = stuck)
      logic [3:0][DW-1:0] rd;       // readdata for beats 3..0
      logic [DW-1:0]     exp_rdata;
      logic              exp_to;
      logic              exp_match;
      int                exp_lat;
      int                exp_strobes;
   } vec_t;

   vec_t vecs[11];

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int   strobes = 0;
      int   beat    = 0;
      int   wcnt    = 0;
      int   lat     = 0;
      bit   prev_done = 0;
      bit   got     = 0;
      logic [DW-1:0] held;
      @(negedge avl_clk);
      check("req_ready_before", {31'd0, bus.req_ready}, 32'd1);
      bus.req_valid   = 1'b1;
      bus.req_op      = v.op;
      bus.req_address = v.addr;
      bus.req_wdata   = v.wdata;
      bus.req_mask    = v.mask;
      @(posedge avl_clk);
      #1 bus.req_valid = 1'b0;
      for (int cyc = 1; cyc <= 40 && !got; cyc++) begin
         @(negedge avl_clk);
         if (bus.avl_read && bus.avl_write) check("dual_strobe", 32'd1, 32'd0);
         if (prev_done) check("gap_idle", {31'd0, bus.avl_read | bus.avl_write}, 32'd0);
         prev_done = 0;
         if (bus.avl_read || bus.avl_write) begin
            strobes++;
            check("avl_address", {16'd0, bus.avl_address}, {16'd0, v.addr});
            check("strobe_is_write", {31'd0, bus.avl_write}, {31'd0, v.op == 2'b00});
            if (bus.avl_write) check("avl_writedata", bus.avl_writedata, v.wdata);
            if (wcnt < v.waits) begin
               bus.avl_waitrequest = 1'b1;
               wcnt++;
            end else begin
               bus.avl_waitrequest = 1'b0;
               bus.avl_readdata    = (beat < 4) ? v.rd[beat] : '0;
               beat++;
               wcnt = 0;
               prev_done = 1;
            end
         end else begin
            bus.avl_waitrequest = 1'b0;
         end
         if (bus.rsp_valid) begin
            got = 1;
            lat = cyc;
            check("rsp_rdata", bus.rsp_rdata, v.exp_rdata);
            check("rsp_timeout", {31'd0, bus.rsp_timeout}, {31'd0, v.exp_to});
            check("rsp_match", {31'd0, bus.rsp_match}, {31'd0, v.exp_match});
         end
      end
      if (!got) begin
         errors++;
         checks++;
         $display("FAIL rsp_wait vec %0d: no rsp_valid within 40 cycles", idx);
      end
      check("latency", lat, v.exp_lat);
      check("strobe_cycles", strobes, v.exp_strobes);
      held = bus.rsp_rdata;
      bus.avl_waitrequest = 1'b0;
      @(negedge avl_clk);
      check("rsp_valid_pulse", {31'd0, bus.rsp_valid}, 32'd0);
      check("req_ready_after", {31'd0, bus.req_ready}, 32'd1);
      check("rsp_rdata_hold", bus.rsp_rdata, v.exp_rdata);
      if (held !== bus.rsp_rdata) check("rsp_rdata_stable", bus.rsp_rdata, held);
   endtask

   initial begin
      //            op     addr      wdata         mask          waits rd{3,2,1,0}                                   rdata         to    m     lat str
      vecs[0]  = '{2'b00, 16'h4000, 32'hDEADBEEF, 32'h0,         0,  {32'h0, 32'h0, 32'h0, 32'h0},               32'h0,        1'b0, 1'b0, 3, 1};
      vecs[1]  = '{2'b01, 16'h5000, 32'h0,        32'h0,         3,  {32'h0, 32'h0, 32'h0, 32'h12345678},        32'h12345678, 1'b0, 1'b0, 6, 4};
      vecs[2]  = '{2'b10, 16'h5000, 32'h1,        32'h1,         0,  {32'h0, 32'h1, 32'h0, 32'h0},               32'h1,        1'b0, 1'b1, 7, 3};
      vecs[3]  = '{2'b10, 16'h5000, 32'h1,        32'h1,         0,  {32'h0, 32'h0, 32'h0, 32'h0},               32'h0,        1'b0, 1'b0, 9, 4};
      vecs[4]  = '{2'b01, 16'h6000, 32'h0,        32'h0,         255,{32'h0, 32'h0, 32'h0, 32'hFFFFFFFF},        32'h0,        1'b1, 1'b0, 9, 8};
      vecs[5]  = '{2'b11, 16'h0123, 32'h0,        32'h0,         1,  {32'h0, 32'h0, 32'h0, 32'hA5A5A5A5},        32'hA5A5A5A5, 1'b0, 1'b0, 4, 2};
      vecs[6]  = '{2'b10, 16'h0044, 32'h30,       32'hF0,        0,  {32'h0, 32'h0, 32'h0, 32'h3F},              32'h3F,       1'b0, 1'b1, 3, 1};
      vecs[7]  = '{2'b10, 16'h0044, 32'h30,       32'hF0,        255,{32'h0, 32'h0, 32'h0, 32'h30},              32'h0,        1'b1, 1'b0, 9, 8};
      vecs[8]  = '{2'b00, 16'h7FFF, 32'h0BADF00D, 32'h0,         2,  {32'h0, 32'h0, 32'h0, 32'h55},              32'h0,        1'b0, 1'b0, 5, 3};
      vecs[9]  = '{2'b10, 16'h1111, 32'h1,        32'h1,         1,  {32'h0, 32'h0, 32'h1, 32'h0},               32'h1,        1'b0, 1'b1, 7, 4};
      vecs[10] = '{2'b01, 16'h2222, 32'h0,        32'h0,         0,  {32'h0, 32'h0, 32'h0, 32'hCAFEF00D},        32'hCAFEF00D, 1'b0, 1'b0, 3, 1};

      bus.req_valid       = 1'b0;
      bus.req_op          = 2'b00;
      bus.req_address     = '0;
      bus.req_wdata       = '0;
      bus.req_mask        = '0;
      bus.avl_readdata    = '0;
      bus.avl_waitrequest = 1'b0;

      repeat (2) @(negedge avl_clk);
      check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
      check("rst_avl_read", {31'd0, bus.avl_read}, 32'd0);
      check("rst_avl_write", {31'd0, bus.avl_write}, 32'd0);
      check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
      check("rst_avl_address", {16'd0, bus.avl_address}, 32'd0);
      check("rst_flags", {30'd0, bus.rsp_timeout, bus.rsp_match}, 32'd0);
      avl_reset = 1'b0;

      for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

      // Reset asserted mid-ACCESS: strobe must drop without a clock edge.
      @(negedge avl_clk);
      bus.req_valid       = 1'b1;
      bus.req_op          = 2'b01;
      bus.req_address     = 16'h3333;
      bus.avl_waitrequest = 1'b1;
      @(posedge avl_clk);
      #1 bus.req_valid = 1'b0;
      @(negedge avl_clk);
      check("pre_rst_read", {31'd0, bus.avl_read}, 32'd1);
      @(negedge avl_clk);
      #2 avl_reset = 1'b1;
      #1;
      check("async_rst_read", {31'd0, bus.avl_read}, 32'd0);
      check("async_rst_ready", {31'd0, bus.req_ready}, 32'd1);
      check("async_rst_addr", {16'd0, bus.avl_address}, 32'd0);
      repeat (2) @(negedge avl_clk);
      avl_reset = 1'b0;
      bus.avl_waitrequest = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge avl_clk);
         check("post_rst_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
         check("post_rst_ready", {31'd0, bus.req_ready}, 32'd1);
      end
      run_vec(0, vecs[0]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
